// File: rtl/mem_wb_stage_pkg.sv
// Shared types and constants for the MEM/WB writeback stage.
// Holds load funct3 codes, the FSM state encoding and a misalignment helper.
// No logic; imported by the interface, the aligner and the stage top.
package mem_wb_stage_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int RADDR_W_DEF = 5;

  // Load funct3 codes (RV32I)
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Writeback FSM states, 2-bit encoding
  typedef enum logic [1:0] {
    WB_IDLE  = 2'd0,
    WB_WAIT  = 2'd1,
    WB_DRAIN = 2'd2
  } wb_state_t;

  // True when a halfword/word load is not naturally aligned
  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] off);
    logic r;
    r = 1'b0;
    if ((op == F3_LH) || (op == F3_LHU)) r = off[0];
    else if (op == F3_LW)                r = (off != 2'b00);
    return r;
  endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// MEM-side, memory-controller, pipeline-control and regfile-write bundle.
// master = MEM stage / memory controller / ctrl side; slave = writeback stage.
// Signal names follow the pipeline's existing port names.
interface mem_wb_stage_if #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
);
  logic               mem_valid;
  logic               mem_wreg;
  logic [RADDR_W-1:0] mem_waddr;
  logic [XLEN-1:0]    mem_wdata;
  logic               mem_is_load;
  logic [2:0]         mem_load_op;
  logic [1:0]         mem_byte_off;
  logic               ld_rvalid;
  logic [XLEN-1:0]    ld_rdata;
  logic               stall_i;
  logic               flush_i;
  logic               wb_we;
  logic [RADDR_W-1:0] wb_waddr;
  logic [XLEN-1:0]    wb_wdata;
  logic               stallreq_o;

  modport master (
    output mem_valid, mem_wreg, mem_waddr, mem_wdata, mem_is_load,
           mem_load_op, mem_byte_off, ld_rvalid, ld_rdata, stall_i, flush_i,
    input  wb_we, wb_waddr, wb_wdata, stallreq_o
  );

  modport slave (
    input  mem_valid, mem_wreg, mem_waddr, mem_wdata, mem_is_load,
           mem_load_op, mem_byte_off, ld_rvalid, ld_rdata, stall_i, flush_i,
    output wb_we, wb_waddr, wb_wdata, stallreq_o
  );
endinterface

// File: rtl/mem_wb_stage_load_align.sv
// Load aligner: picks the byte/half lane from a word and sign/zero-extends it.
// Latency: purely combinational.
// Backpressure: none; unknown funct3 yields zero data and o_valid_op=0.
module load_align
  import mem_wb_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      i_load_op,
  input  logic [1:0]      i_byte_off,
  input  logic [XLEN-1:0] i_rdata,
  output logic [XLEN-1:0] o_data,
  output logic            o_valid_op
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane select: byte by full offset, half by offset[1] (offset[0] ignored)
  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_byte_off)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_byte_off[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  // Extension per funct3
  always_comb begin
    o_data     = '0;
    o_valid_op = 1'b1;
    case (i_load_op)
      F3_LB:   o_data = {{(XLEN-8){w_byte[7]}}, w_byte};
      F3_LBU:  o_data = {{(XLEN-8){1'b0}}, w_byte};
      F3_LH:   o_data = {{(XLEN-16){w_half[15]}}, w_half};
      F3_LHU:  o_data = {{(XLEN-16){1'b0}}, w_half};
      F3_LW:   o_data = i_rdata;
      default: o_valid_op = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB stage: registers MEM results, waits for load data, drives a 1-cycle regfile write.
// Latency: 1 cycle for non-loads; 1 cycle after ld_rvalid for loads.
// Backpressure: stallreq_o high while a load is outstanding (WAIT/DRAIN); MEM_WB_MISALIGN_TRAP_EN adds misalign_o.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int RADDR_W = RADDR_W_DEF
) (
  input  logic          clk,
  input  logic          rst,
  mem_wb_stage_if.slave bus
`ifdef MEM_WB_MISALIGN_TRAP_EN
  ,
  output logic          misalign_o
`endif
);

  wb_state_t          r_state, w_state_nxt;

  logic               r_ld_wreg;
  logic [RADDR_W-1:0] r_ld_waddr;
  logic [2:0]         r_ld_op;
  logic [1:0]         r_ld_off;
  logic               w_capture;

  logic               r_wb_we,    w_we_nxt;
  logic [RADDR_W-1:0] r_wb_waddr, w_waddr_nxt;
  logic [XLEN-1:0]    r_wb_wdata, w_wdata_nxt;

  logic [XLEN-1:0]    w_align_data;
  logic               w_align_ok;

`ifdef MEM_WB_MISALIGN_TRAP_EN
  logic               w_misalign;
  logic               r_misalign, w_misalign_nxt;
  assign w_misalign = is_misaligned(r_ld_op, r_ld_off);
  assign misalign_o = r_misalign;
`endif

  // Alignment works on the latched load attributes and the returning word
  load_align #(.XLEN(XLEN)) u_load_align (
    .i_load_op  (r_ld_op),
    .i_byte_off (r_ld_off),
    .i_rdata    (bus.ld_rdata),
    .o_data     (w_align_data),
    .o_valid_op (w_align_ok)
  );

  // Next state and next writeback values; flush outranks normal state logic
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_we_nxt    = 1'b0;
    w_waddr_nxt = r_wb_waddr;
    w_wdata_nxt = r_wb_wdata;
`ifdef MEM_WB_MISALIGN_TRAP_EN
    w_misalign_nxt = 1'b0;
`endif
    if (bus.flush_i) begin
      // In WAIT/DRAIN the load is still in flight; its return must be swallowed
      if (r_state != WB_IDLE) w_state_nxt = bus.ld_rvalid ? WB_IDLE : WB_DRAIN;
    end else begin
      case (r_state)
        WB_IDLE: begin
          if (bus.mem_valid && !bus.stall_i) begin
            if (bus.mem_is_load) begin
              w_capture   = 1'b1;
              w_state_nxt = WB_WAIT;
            end else begin
              w_we_nxt    = bus.mem_wreg && (bus.mem_waddr != '0);
              w_waddr_nxt = bus.mem_waddr;
              w_wdata_nxt = bus.mem_wdata;
            end
          end
        end
        WB_WAIT: begin
          if (bus.ld_rvalid) begin
            w_state_nxt = WB_IDLE;
            w_we_nxt    = r_ld_wreg && (r_ld_waddr != '0) && w_align_ok;
            w_waddr_nxt = r_ld_waddr;
            w_wdata_nxt = w_align_data;
`ifdef MEM_WB_MISALIGN_TRAP_EN
            w_misalign_nxt = w_misalign;
            if (w_misalign) w_we_nxt = 1'b0;
`endif
          end
        end
        WB_DRAIN: begin
          if (bus.ld_rvalid) w_state_nxt = WB_IDLE;
        end
        default: w_state_nxt = WB_IDLE;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= WB_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Writeback pipeline register and latched load attributes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb_we    <= 1'b0;
      r_wb_waddr <= '0;
      r_wb_wdata <= '0;
      r_ld_wreg  <= 1'b0;
      r_ld_waddr <= '0;
      r_ld_op    <= '0;
      r_ld_off   <= '0;
`ifdef MEM_WB_MISALIGN_TRAP_EN
      r_misalign <= 1'b0;
`endif
    end else begin
      r_wb_we    <= w_we_nxt;
      r_wb_waddr <= w_waddr_nxt;
      r_wb_wdata <= w_wdata_nxt;
`ifdef MEM_WB_MISALIGN_TRAP_EN
      r_misalign <= w_misalign_nxt;
`endif
      if (w_capture) begin
        r_ld_wreg  <= bus.mem_wreg;
        r_ld_waddr <= bus.mem_waddr;
        r_ld_op    <= bus.mem_load_op;
        r_ld_off   <= bus.mem_byte_off;
      end
    end
  end

  assign bus.wb_we      = r_wb_we;
  assign bus.wb_waddr   = r_wb_waddr;
  assign bus.wb_wdata   = r_wb_wdata;
  assign bus.stallreq_o = (r_state != WB_IDLE);

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Final pipeline stage of the 5-stage RV32I core. Sits between the MEM stage / data-memory controller and the register file write port.
- Registers MEM results, waits for multi-cycle load data, and aligns and extends load bytes/halves.
- Drives the regfile we/waddr/wdata as a one-cycle write pulse, and requests a pipeline stall while a load is outstanding.

Parameters:
- XLEN, 32, data width; must equal the `RegBus width from defines.vh
- RADDR_W, 5, register address width; must equal the `RegAddrBus width

Ports:
- clk  input  1  core clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset (`RstEnable)
- mem_valid  input  1  MEM stage presents a valid instruction this cycle
- mem_wreg  input  1  instruction writes rd
- mem_waddr  input  RADDR_W  rd index
- mem_wdata  input  XLEN  ALU/CSR result for non-loads
- mem_is_load  input  1  instruction is a load; data comes via ld_rvalid
- mem_load_op  input  3  load funct3
- mem_byte_off  input  2  effective address [1:0]
- ld_rvalid  input  1  memory controller returns load word this cycle
- ld_rdata  input  XLEN  word-aligned load data
- stall_i  input  1  ctrl holds this stage; no capture this cycle
- flush_i  input  1  ctrl kills in-flight work
- wb_we  output  1  regfile write enable
- wb_waddr  output  RADDR_W  regfile write address
- wb_wdata  output  XLEN  regfile write data
- stallreq_o  output  1  combinational from state; high in WAIT or DRAIN

Behaviour:
- Reset: state=IDLE. wb_we=0, wb_waddr=0, wb_wdata=0, stallreq_o=0. Latched load info is cleared.
- States and transitions:
  - IDLE
    - mem_valid & !stall_i & !mem_is_load: register the result. The next cycle shows wb_we=mem_wreg & (mem_waddr!=0), wb_waddr, wb_wdata for exactly one cycle.
    - mem_valid & !stall_i & mem_is_load: latch waddr, wreg, load_op and byte_off. Go to WAIT. wb_we=0.
    - stall_i=1 or mem_valid=0: wb_we=0 next cycle (bubble); wb_waddr/wb_wdata hold.
  - WAIT
    - Ignores mem_* and stall_i.
    - On ld_rvalid: next cycle wb_we=latched wreg & (waddr!=0), wb_wdata=aligned data. Go to IDLE.
    - Without ld_rvalid: stay; wb_we=0.
  - DRAIN (entered on flush during WAIT)
    - Waits for ld_rvalid, discards the data, then goes to IDLE.
    - Never writes.
- Load alignment (lane = byte_off):
  - 000 LB: sign-extend byte[lane]
  - 100 LBU: zero-extend byte[lane]
  - 001 LH: sign-extend half[byte_off[1]]
  - 101 LHU: zero-extend half[byte_off[1]]
  - 010 LW: word as-is
  - Any other funct3: wb_we=0, data=0
- Misaligned LH/LW: the low address bit(s) are ignored; no trap.
- Priority per edge: rst > flush_i > state logic.
  - flush_i in IDLE: wb_we=0 next cycle; nothing captured.
  - flush_i in WAIT: go to DRAIN.
  - flush_i in DRAIN: stay in DRAIN.
  - flush_i together with ld_rvalid in WAIT or DRAIN: go to IDLE, no write.
- ld_rvalid in IDLE: ignored.
- Timing: latency MEM→regfile write = 1 cycle for non-loads, and 1 cycle after ld_rvalid for loads. Back-to-back non-loads write every cycle.
- Reset while in WAIT/DRAIN: returns to IDLE. The memory controller is reset by the same rst, so no stale ld_rvalid follows.

Optional Feature:
- Macro: MEM_WB_MISALIGN_TRAP_EN.
- When defined:
  - Extra output misalign_o (1 bit). It pulses for one cycle, aligned with the would-be write, when LH/LHU has byte_off[0]=1 or LW has byte_off!=0.
  - That write is suppressed (wb_we=0).
- When undefined:
  - No port.
  - Misaligned loads write the aligned-lane data as above.

Decomposition:
- defines.vh gains:
  - load funct3 codes (`LB, `LH, `LW, `LBU, `LHU)
  - state encodings (`WbIdle, `WbWait, `WbDrain, 2 bits)
- Reuse existing `RegBus, `RegAddrBus, `RstEnable, `WriteEnable and `ZeroWord.
- One combinational sub-module, load_align:
  - inputs: load_op, byte_off, rdata
  - outputs: aligned data and a valid_op flag
- The FSM and pipeline register stay in mem_wb_stage.

Test Plan:
- Non-load: mem_valid=1, wreg=1, waddr=5, wdata=0xDEADBEEF → next cycle wb_we=1, waddr=5, wdata=0xDEADBEEF; following cycle wb_we=0.
- LB: waddr=x0, any data → no write. LB: waddr=3, off=2, ld_rdata=0x12F45678 after 4 cycles → stallreq_o high for 4 cycles, then wb_wdata=0xFFFFFFF4. LBU gives 0x000000F4.
- LH: off=2, ld_rdata=0x80001234 → 0xFFFF8000. LHU gives 0x00008000. LW gives 0x80001234.
- Flush: flush_i one cycle into WAIT; ld_rvalid 3 cycles later → DRAIN, stallreq_o stays high until ld_rvalid, never wb_we; the next non-load writes normally.
- Stall in IDLE: stall_i=1 with a valid non-load → wb_we=0; release with the same inputs → one write.
- MEM_WB_MISALIGN_TRAP_EN defined: LW with off=1 → misalign_o pulses, wb_we=0. Undefined: the same stimulus writes the word.
